mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory access sequencer for the multicycle core; sits directly upstream of the memory data register.
- Accepts one load/store command from the control FSM and runs a valid/ready request and response exchange with data memory.
- For stores, it generates byte strobes and lane-replicated write data.
- For loads, it aligns and sign- or zero-extends the returned word and presents the result on load_data, which drives the MDR input.

Parameters:
- TIMEOUT, 64: max cycles spent in REQ+WAIT_RSP before aborting with fault; 0 disables timeout.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe from control FSM; sampled only in IDLE
- is_store  in  1  1=store, 0=load
- funct3  in  3  RV32I width/sign code (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2)
- addr  in  32  byte address
- store_data  in  32  rs2 value
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- misaligned  out  1  valid with done: misaligned or illegal funct3
- fault  out  1  valid with done: timeout abort
- load_data  out  32  extended load result; holds until next successful load
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write request
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables (0 for loads)
- mem_rsp_valid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including load_data; timeout counter cleared. Asserting reset mid-transaction abandons it immediately; no done pulse follows.
- States are IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - start=1 latches is_store, funct3, addr, store_data.
  - Error check on the latched command:
    - halfword with addr[0]=1 → error
    - word with addr[1:0]!=0 → error
    - load funct3 in {3,6,7} → error
    - store funct3 >= 3 → error
  - Error: go to DONE with misaligned=1. No memory request is issued.
  - Otherwise: go to REQ.
- REQ:
  - mem_req_valid=1.
  - mem_we, mem_addr, mem_wdata and mem_wstrb come from latched values and stay stable until accepted.
  - On valid&&ready:
    - store → DONE
    - load → WAIT_RSP
- WAIT_RSP:
  - When mem_rsp_valid=1, capture the extended result into load_data and go to DONE.
  - mem_req_valid=0 in this state.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - misaligned and fault are meaningful only while done=1; they are 0 otherwise.
- start is ignored while busy (including in DONE). mem_rsp_valid is ignored outside WAIT_RSP.
- Timeout:
  - Counter is cleared on entry to REQ and increments each cycle in REQ/WAIT_RSP.
  - If TIMEOUT!=0 and count reaches TIMEOUT-1 without completion, go to DONE with fault=1. load_data is unchanged.
  - If completion and timeout occur in the same cycle, completion wins and fault=0.
- Store lanes (o = addr[1:0]):
  - SB: wdata = {4{sd[7:0]}}, wstrb = 4'b0001<<o
  - SH: wdata = {2{sd[15:0]}}, wstrb = o[1] ? 1100 : 0011
  - SW: wdata = sd, wstrb = 1111
- Load extract:
  - byte = rdata[8*o +: 8]; half = rdata[16*o[1] +: 16]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Latency with zero-wait memory (start in cycle T):
  - Store: accepted T+1, done T+2.
  - Load with rsp_valid in the cycle after acceptance: done T+3, load_data valid from T+3.
  - Error: done T+1.

Test Plan:
- LB addr=0x1003, rdata=0x80FF_1234 → mem_addr=0x1000, wstrb=0, load_data=0xFFFF_FF80, done at T+3, misaligned=0.
- LHU addr=0x2002, rdata=0xBEEF_0000 → load_data=0x0000_BEEF. Same beat with LH → load_data=0xFFFF_BEEF.
- SB addr=0x11, sd=0xAABB_CCDD, ready held low 3 cycles → valid/wdata=0xDDDD_DDDD/wstrb=0010 stable for all stall cycles; done 1 cycle after acceptance.
- LW addr=0x6 → no mem_req_valid, done at T+1 with misaligned=1, load_data unchanged. Second start pulsed during busy → ignored.
- TIMEOUT=8, load with mem_rsp_valid never asserted → done with fault=1 exactly 8 cycles after entering REQ. A late rsp_valid afterwards has no effect.
- rst_n low during WAIT_RSP → all outputs 0 immediately. After release, a new SW addr=0x40 sd=0x1234_5678 → wstrb=1111, wdata=0x1234_5678.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory load/store sequencer for the multicycle core.
// Runs one valid/ready request (+ read response) per command and aligns data.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start/is_store/funct3  command from control FSM (sampled in IDLE)
//   addr/store_data        byte address and rs2 value
//   busy/done              activity flag, one-cycle completion pulse
//   misaligned/fault       status, valid while done=1
//   load_data              extended load result (drives MDR)
//   mem_req_*/mem_we/...   request channel to data memory
//   mem_rsp_valid/rdata    read response from data memory
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW =
    (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TLIM =
    (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] TLIM_C = TLIM[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          err_q, err_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   ld_q, ld_d;
  logic          tmo;
  logic          acc;
  logic [7:0]    rb;
  logic [15:0]   rh;

  assign acc = mem_req_valid && mem_req_ready;
  assign tmo = (TIMEOUT != 0) && (cnt_q == TLIM_C);

  // command legality and alignment
  always_comb begin
    err_d = 1'b0;
    if (is_store)
      err_d = (funct3 >= 3'd3);
    else
      err_d = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
    if (funct3[1:0] == 2'd1 && addr[0])
      err_d = 1'b1;
    if (funct3[1:0] == 2'd2 && addr[1:0] != 2'd0)
      err_d = 1'b1;
  end

  // store lane replication and byte enables
  always_comb begin
    wdata_d = store_data;
    wstrb_d = 4'b0000;
    if (is_store) begin
      unique case (1'b1)
        funct3[1:0] == 2'd0: begin
          wdata_d = {4{store_data[7:0]}};
          wstrb_d = 4'b0001 << addr[1:0];
        end
        funct3[1:0] == 2'd1: begin
          wdata_d = {2{store_data[15:0]}};
          wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_d = store_data;
          wstrb_d = 4'b1111;
        end
      endcase
    end
  end

  // load lane extraction and extension
  assign rb = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign rh = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    unique case (f3_q)
      3'd0:    ld_d = {{24{rb[7]}}, rb};
      3'd1:    ld_d = {{16{rh[15]}}, rh};
      3'd4:    ld_d = {24'd0, rb};
      3'd5:    ld_d = {16'd0, rh};
      default: ld_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // completion beats timeout when both land in one cycle
  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = err_d ? S_DONE : S_REQ;
      S_REQ:
        if (acc) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (tmo) begin
          state_d = S_DONE;
          fault_d = 1'b1;
        end
      S_WAIT:
        if (mem_rsp_valid) begin
          state_d = S_DONE;
        end else if (tmo) begin
          state_d = S_DONE;
          fault_d = 1'b1;
        end
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    misaligned    = done && err_q;
    fault         = done && fault_q;
    mem_req_valid = (state_q == S_REQ);
  end

  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign load_data = ld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= 32'd0;
    end else begin
      if (state_q == S_IDLE && start) begin
        we_q    <= is_store;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        err_q   <= err_d;
        fault_q <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == S_REQ || state_q == S_WAIT) begin
        cnt_q   <= cnt_q + CW'(1);
        fault_q <= fault_d;
      end
      if (state_q == S_WAIT && mem_rsp_valid)
        ld_q <= ld_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + random checks of mem_access_unit
// against a cycle-offset reference model.
module tb_mem_access_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy, done, misaligned, fault;
  logic [31:0] load_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ld_model = 32'd0;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data),
    .busy(busy), .done(done),
    .misaligned(misaligned), .fault(fault),
    .load_data(load_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic cmd_bad(input logic st,
                                   input logic [2:0] f,
                                   input logic [31:0] a);
    logic b;
    if (st) b = (f > 3'd2);
    else    b = !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((f % 4) == 1 && (a % 2) != 0) b = 1'b1;
    if ((f % 4) == 2 && (a % 4) != 0) b = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned o;
    logic [31:0] w;
    o = a % 4;
    case (f)
      3'd0, 3'd4: begin
        w = (rd >> (8 * o)) & 32'hFF;
        if (f == 3'd0 && w >= 32'd128) w = w | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        w = (rd >> (16 * (o / 2))) & 32'hFFFF;
        if (f == 3'd1 && w >= 32'd32768) w = w | 32'hFFFF_0000;
      end
      default: w = rd;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] st_wdata(input logic [2:0] f,
                                           input logic [31:0] sd);
    if (f == 3'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f == 3'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] st_wstrb(input logic [2:0] f,
                                          input logic [31:0] a);
    int unsigned o;
    o = a % 4;
    if (f == 3'd0) return 4'(1 << o);
    if (f == 3'd1) return (o >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  // r: cycles ready held low in REQ; d: cycles rsp held low in WAIT.
  // Cycle c counts from the start cycle (c=0).
  task automatic run_cmd(input logic st, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int r,
                         input int d, input logic hold);
    logic bad, flt;
    int k, kk, dn, vend;
    logic [31:0] ewd;
    logic [3:0] ews;
    bad  = cmd_bad(st, f, a);
    k    = st ? r : r + 1 + d;
    flt  = !bad && (k > TMO - 1);
    kk   = (k > TMO - 1) ? TMO - 1 : k;
    dn   = bad ? 1 : kk + 2;
    vend = bad ? 0 : 1 + ((r > TMO - 1) ? TMO - 1 : r);
    ews  = st ? st_wstrb(f, a) : 4'h0;
    ewd  = st_wdata(f, sd);
    for (int c = 0; c <= dn + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b1; is_store = st; funct3 = f;
        addr = a; store_data = sd;
      end else begin
        start      = hold && (c <= dn);
        is_store   = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
      end
      mem_req_ready = (c >= 1 + r);
      mem_rsp_valid = !st && (c == 2 + r + d);
      mem_rdata     = mem_rsp_valid ? rd : $urandom;
      @(negedge clk);
      chk("done", 32'(done), 32'(c == dn));
      chk("busy", 32'(busy), 32'(c >= 1 && c <= dn));
      chk("req_valid", 32'(mem_req_valid),
          32'(c >= 1 && c <= vend));
      if (c >= 1 && c <= vend) begin
        chk("mem_addr", mem_addr, a & ~32'd3);
        chk("mem_we", 32'(mem_we), 32'(st));
        chk("wstrb", 32'(mem_wstrb), 32'(ews));
        if (st) chk("wdata", mem_wdata, ewd);
      end
      if (c == dn) begin
        chk("misaligned", 32'(misaligned), 32'(bad));
        chk("fault", 32'(fault), 32'(flt));
        if (!st && !bad && !flt) ld_model = ld_ext(f, a, rd);
      end else begin
        chk("flags_quiet", {30'd0, misaligned, fault}, 32'd0);
      end
      chk("load_data", load_data, ld_model);
    end
    start = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"},
        {26'd0, busy, done, misaligned, fault,
         mem_req_valid, mem_we}, 32'd0);
    chk({tag, "_ld"}, load_data, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
  endtask

  initial begin
    logic st;
    logic [2:0] f;
    logic [31:0] a;
    int r, d;

    #12;
    chk_all_zero("reset");
    #1 rst_n = 1'b1;

    // LB sign-extended top byte, zero-wait memory
    run_cmd(1'b0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    chk("lb_val", load_data, 32'hFFFF_FF80);
    // LHU then LH of the same beat
    run_cmd(1'b0, 3'd5, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 0, 1'b0);
    chk("lhu_val", load_data, 32'h0000_BEEF);
    run_cmd(1'b0, 3'd1, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 0, 1'b0);
    chk("lh_val", load_data, 32'hFFFF_BEEF);
    // SB with ready stalled 3 cycles
    run_cmd(1'b1, 3'd0, 32'h11, 32'hAABB_CCDD, 32'h0, 3, 0, 1'b0);
    // misaligned LW, start held during busy
    run_cmd(1'b0, 3'd2, 32'h6, 32'h0, 32'h0, 0, 0, 1'b1);
    // illegal funct3 codes
    run_cmd(1'b0, 3'd3, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    run_cmd(1'b1, 3'd4, 32'h0, 32'h5, 32'h0, 0, 0, 1'b0);
    // timeout: response never arrives in time
    run_cmd(1'b0, 3'd2, 32'h100, 32'h0, 32'h1111_2222, 0, 30, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_rsp_ld", load_data, ld_model);
    chk("late_rsp_done", 32'(done), 32'd0);
    mem_rsp_valid = 1'b0;
    // boundary: completion exactly at the timeout cycle wins
    run_cmd(1'b1, 3'd2, 32'h200, 32'h5A5A_A5A5, 32'h0, 7, 0, 1'b0);
    run_cmd(1'b0, 3'd4, 32'h201, 32'h0, 32'h0000_9900, 3, 3, 1'b0);

    // reset while waiting for a load response
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2;
    addr = 32'h80; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    ld_model = 32'd0;
    #3 rst_n = 1'b1;
    run_cmd(1'b1, 3'd2, 32'h40, 32'h1234_5678, 32'h0, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f = 3'($urandom);
      else if (st) f = 3'($urandom_range(0, 2));
      else begin
        f = 3'($urandom_range(0, 4));
        if (f == 3'd3) f = 3'd5;
      end
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'd3;
      r = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 4);
      d = $urandom_range(0, 4);
      run_cmd(st, f, a, $urandom, $urandom, r, d,
              1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
